// File: rtl/ret_canary_checker_pkg.sv
// Shared types and helpers for the return-canary checker: modes, FSM states,
// a minimal scoreboard entry and the RET / marker-NOP recognisers.
package ret_canary_pkg;

   localparam int unsigned SEQ_LEN_MAX = 8;
   localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

   typedef enum logic [1:0] {
      MODE_OFF = 2'b00,
      MODE_MON = 2'b01,
      MODE_ENF = 2'b10
   } mode_e;

   typedef enum logic {
      IDLE,
      CHECK
   } state_e;

   typedef enum logic [7:0] {
      ADD,
      SUB,
      LUI,
      JAL,
      JALR,
      BEQ,
      LOAD,
      STORE
   } fu_op_t;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;

   typedef struct packed {
      logic [31:0] pc;
      fu_op_t      op;
      logic [5:0]  rs1;
      logic [5:0]  rs2;
      logic [5:0]  rd;
      logic [63:0] result;
      exception_t  ex;
   } sb_t;

   // Encoding 2'b11 is treated as enforce as well.
   function automatic mode_e decode_mode(logic [1:0] m);
      case (m)
         2'b00:   return MODE_OFF;
         2'b01:   return MODE_MON;
         default: return MODE_ENF;
      endcase
   endfunction

   function automatic logic is_ret(sb_t e, logic alt);
      return !e.ex.valid && (e.op == JALR) && (e.rd == '0) &&
             ((e.rs1 == 6'd1) || (alt && (e.rs1 == 6'd5)));
   endfunction

   function automatic logic is_marker(sb_t e, fu_op_t op, logic [4:0] rd,
                                      logic [4:0] rs1, logic [4:0] imm);
      return (e.op == op) && (e.rd[4:0] == rd) && (e.rs1[4:0] == rs1) &&
             (e.result[4:0] == imm);
   endfunction

endpackage

// File: rtl/ret_canary_checker_sat_counter.sv
// Saturating up-counter; a clear request takes priority over an increment.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_o <= '0;
      end else if (clr_i) begin
         cnt_o <= '0;
      end else if (inc_i && (cnt_o != '1)) begin
         cnt_o <= cnt_o + W'(1);
      end
   end

endmodule

// File: rtl/ret_canary_checker.sv
// In-line checker on the decode-to-issue path: after a function return, the next
// SEQ_LEN accepted entries must be marker NOPs, otherwise a violation is flagged.
module ret_canary_checker
   import ret_canary_pkg::*;
#(
   parameter fu_op_t      NOP_OP   = ADD,
   parameter logic [4:0]  NOP_RD   = 5'd0,
   parameter logic [4:0]  NOP_RS1  = 5'd0,
   parameter logic [4:0]  NOP_IMM  = 5'd1,
   parameter int unsigned SEQ_LEN  = 1,
   parameter logic        ALT_LINK = 1'b0,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic [1:0]       mode_i,
   input  logic             clr_cnt_i,
   input  logic             valid_i,
   input  logic             ack_i,
   input  sb_t              entry_i,
   output sb_t              entry_o,
   output logic             busy_o,
   output logic             violation_o,
   output logic [CNT_W-1:0] violation_cnt_o
);

   localparam int unsigned IDX_W = $clog2(SEQ_LEN) + 1;

   if ((SEQ_LEN < 1) || (SEQ_LEN > SEQ_LEN_MAX)) begin : g_bad_seq_len
      $error("ret_canary_checker: SEQ_LEN out of range 1..8");
   end

   state_e           state;
   logic [IDX_W-1:0] idx;
   mode_e            mode;
   logic             active;
   logic             enforce;
   logic             xfer;
   logic             mismatch;
   logic             last;
   logic             viol;
   logic             tag;

   always_comb begin
      mode     = decode_mode(mode_i);
      active   = (mode != MODE_OFF);
      enforce  = (mode == MODE_ENF);
      xfer     = valid_i && ack_i;
      last     = (idx == IDX_W'(SEQ_LEN - 1));
      // Entries already carrying an exception are never judged against the marker.
      mismatch = (state == CHECK) && active && !entry_i.ex.valid &&
                 !is_marker(entry_i, NOP_OP, NOP_RD, NOP_RS1, NOP_IMM);
      tag      = mismatch && valid_i && enforce && !flush_i;
      viol     = mismatch && xfer && !flush_i;
   end

   always_comb begin
      entry_o = entry_i;
      if (tag) begin
         entry_o.ex.valid = 1'b1;
         entry_o.ex.cause = ILLEGAL_INSTR;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         idx         <= '0;
         busy_o      <= 1'b0;
         violation_o <= 1'b0;
      end else begin
         violation_o <= viol;
         if (flush_i) begin
            state  <= IDLE;
            idx    <= '0;
            busy_o <= 1'b0;
         end else if (xfer) begin
            case (state)
               IDLE: begin
                  if (active && is_ret(entry_i, ALT_LINK)) begin
                     state  <= CHECK;
                     idx    <= '0;
                     busy_o <= 1'b1;
                  end
               end
               CHECK: begin
                  if (!active || entry_i.ex.valid || mismatch || last) begin
                     state  <= IDLE;
                     idx    <= '0;
                     busy_o <= 1'b0;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
               default: begin
                  state  <= IDLE;
                  idx    <= '0;
                  busy_o <= 1'b0;
               end
            endcase
         end
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_cnt (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .inc_i(viol),
      .clr_i(clr_cnt_i),
      .cnt_o(violation_cnt_o)
   );

endmodule

// File: tb/tb_ret_canary_checker.sv
// Directed bench: four checker instances with different parameters share one
// stimulus stream; each scenario resets all of them and checks the relevant one.
module tb_ret_canary_checker;
   import ret_canary_pkg::*;

   logic       clk;
   logic       rst;
   logic       flush;
   logic [1:0] mode;
   logic       clr;
   logic       valid;
   logic       ack;
   sb_t        ent;

   sb_t         eo_a, eo_b, eo_c, eo_d;
   logic        busy_a, busy_b, busy_c, busy_d;
   logic        viol_a, viol_b, viol_c, viol_d;
   logic [15:0] cnt_a, cnt_b, cnt_d;
   logic [1:0]  cnt_c;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   ret_canary_checker #(.SEQ_LEN(1)) u_a (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .mode_i(mode), .clr_cnt_i(clr),
      .valid_i(valid), .ack_i(ack), .entry_i(ent), .entry_o(eo_a),
      .busy_o(busy_a), .violation_o(viol_a), .violation_cnt_o(cnt_a));

   ret_canary_checker #(.SEQ_LEN(3)) u_b (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .mode_i(mode), .clr_cnt_i(clr),
      .valid_i(valid), .ack_i(ack), .entry_i(ent), .entry_o(eo_b),
      .busy_o(busy_b), .violation_o(viol_b), .violation_cnt_o(cnt_b));

   ret_canary_checker #(.SEQ_LEN(2), .CNT_W(2)) u_c (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .mode_i(mode), .clr_cnt_i(clr),
      .valid_i(valid), .ack_i(ack), .entry_i(ent), .entry_o(eo_c),
      .busy_o(busy_c), .violation_o(viol_c), .violation_cnt_o(cnt_c));

   ret_canary_checker #(.SEQ_LEN(1), .ALT_LINK(1'b1)) u_d (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .mode_i(mode), .clr_cnt_i(clr),
      .valid_i(valid), .ack_i(ack), .entry_i(ent), .entry_o(eo_d),
      .busy_o(busy_d), .violation_o(viol_d), .violation_cnt_o(cnt_d));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic sb_t mk(fu_op_t op, logic [5:0] rd, logic [5:0] rs1, logic [63:0] res);
      sb_t e;
      e         = '0;
      e.pc      = 32'h8000_0100;
      e.op      = op;
      e.rd      = rd;
      e.rs1     = rs1;
      e.result  = res;
      e.ex.tval = 64'h0BAD_F00D;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input sb_t e, input logic v, input logic a);
      ent   = e;
      valid = v;
      ack   = a;
      #1;
   endtask

   task automatic do_reset(input logic [1:0] m);
      rst   = 1'b1;
      flush = 1'b0;
      clr   = 1'b0;
      valid = 1'b0;
      ack   = 1'b0;
      mode  = m;
      ent   = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   sb_t ret_e, mark_e, bad_e, jal_e, alt_e, exc_e;

   initial begin
      ret_e  = mk(JALR, 6'd0, 6'd1, 64'd0);
      mark_e = mk(ADD,  6'd0, 6'd0, 64'd1);
      bad_e  = mk(ADD,  6'd0, 6'd0, 64'd2);
      jal_e  = mk(JAL,  6'd1, 6'd0, 64'd16);
      alt_e  = mk(JALR, 6'd0, 6'd5, 64'd0);
      exc_e  = bad_e;
      exc_e.ex.valid = 1'b1;
      exc_e.ex.cause = 64'd5;

      // reset state
      do_reset(2'b10);
      chk("rst_busy", 64'(busy_a), 64'd0);
      chk("rst_viol", 64'(viol_a), 64'd0);
      chk("rst_cnt",  64'(cnt_a),  64'd0);

      // SEQ_LEN=1 enforce, good marker
      put(ret_e, 1'b1, 1'b1);
      chk("ok_ret_pass", 64'(eo_a.ex.valid), 64'd0);
      tick();
      chk("ok_busy1", 64'(busy_a), 64'd1);
      put(mark_e, 1'b1, 1'b1);
      chk("ok_mark_exv", 64'(eo_a.ex.valid), 64'd0);
      chk("ok_mark_res", eo_a.result, 64'd1);
      tick();
      chk("ok_busy0", 64'(busy_a), 64'd0);
      chk("ok_cnt",   64'(cnt_a),  64'd0);
      chk("ok_viol",  64'(viol_a), 64'd0);

      // SEQ_LEN=1 enforce, bad marker; tagged before ack, stall holds state
      do_reset(2'b10);
      put(ret_e, 1'b1, 1'b1);
      tick();
      put(bad_e, 1'b1, 1'b0);
      chk("bad_tag_noack", 64'(eo_a.ex.valid), 64'd1);
      chk("bad_cause",     eo_a.ex.cause, ILLEGAL_INSTR);
      chk("bad_tval",      eo_a.ex.tval, 64'h0BAD_F00D);
      tick();
      chk("bad_stall_busy", 64'(busy_a), 64'd1);
      chk("bad_stall_viol", 64'(viol_a), 64'd0);
      put(bad_e, 1'b1, 1'b1);
      tick();
      chk("bad_viol", 64'(viol_a), 64'd1);
      chk("bad_cnt",  64'(cnt_a),  64'd1);
      chk("bad_busy", 64'(busy_a), 64'd0);
      put(mark_e, 1'b0, 1'b0);
      tick();
      chk("bad_viol_pulse", 64'(viol_a), 64'd0);

      // SEQ_LEN=3 monitor: RET, 2 markers, JAL
      do_reset(2'b01);
      put(ret_e, 1'b1, 1'b1);
      tick();
      put(mark_e, 1'b1, 1'b1);
      tick();
      chk("mon_busy_m1", 64'(busy_b), 64'd1);
      tick();
      chk("mon_busy_m2", 64'(busy_b), 64'd1);
      put(jal_e, 1'b1, 1'b1);
      chk("mon_jal_exv", 64'(eo_b.ex.valid), 64'd0);
      chk("mon_jal_res", eo_b.result, 64'd16);
      tick();
      chk("mon_cnt",  64'(cnt_b),  64'd1);
      chk("mon_viol", 64'(viol_b), 64'd1);
      chk("mon_busy", 64'(busy_b), 64'd0);

      // SEQ_LEN=2 with ack low for 5 cycles
      do_reset(2'b10);
      put(ret_e, 1'b1, 1'b1);
      tick();
      put(mark_e, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_busy", 64'(busy_c), 64'd1);
      end
      put(mark_e, 1'b1, 1'b1);
      chk("stall_mark_exv", 64'(eo_c.ex.valid), 64'd0);
      tick();
      chk("stall_busy_after1", 64'(busy_c), 64'd1);
      tick();
      chk("stall_busy_after2", 64'(busy_c), 64'd0);
      chk("stall_cnt", 64'(cnt_c), 64'd0);

      // flush with a bad entry in the same cycle
      do_reset(2'b10);
      put(ret_e, 1'b1, 1'b1);
      tick();
      flush = 1'b1;
      put(bad_e, 1'b1, 1'b1);
      chk("flush_exv", 64'(eo_a.ex.valid), 64'd0);
      tick();
      flush = 1'b0;
      chk("flush_busy", 64'(busy_a), 64'd0);
      chk("flush_viol", 64'(viol_a), 64'd0);
      chk("flush_cnt",  64'(cnt_a),  64'd0);

      // CNT_W=2 saturation
      do_reset(2'b10);
      for (int i = 0; i < 4; i++) begin
         put(ret_e, 1'b1, 1'b1);
         tick();
         put(bad_e, 1'b1, 1'b1);
         tick();
         chk("sat_cnt", 64'(cnt_c), (i < 3) ? 64'(i + 1) : 64'd3);
      end

      // clear on a violation cycle
      do_reset(2'b10);
      put(ret_e, 1'b1, 1'b1);
      tick();
      put(bad_e, 1'b1, 1'b1);
      tick();
      chk("clr_pre_cnt", 64'(cnt_a), 64'd1);
      put(ret_e, 1'b1, 1'b1);
      tick();
      clr = 1'b1;
      put(bad_e, 1'b1, 1'b1);
      tick();
      clr = 1'b0;
      chk("clr_cnt",  64'(cnt_a),  64'd0);
      chk("clr_viol", 64'(viol_a), 64'd1);

      // ALT_LINK: x5 return arms only the ALT_LINK instance
      do_reset(2'b10);
      put(alt_e, 1'b1, 1'b1);
      tick();
      chk("alt_busy_d", 64'(busy_d), 64'd1);
      chk("alt_busy_a", 64'(busy_a), 64'd0);
      put(mark_e, 1'b1, 1'b1);
      chk("alt_exv_d", 64'(eo_d.ex.valid), 64'd0);
      tick();
      chk("alt_done_d", 64'(busy_d), 64'd0);
      chk("alt_viol_d", 64'(viol_d), 64'd0);
      chk("alt_cnt_d",  64'(cnt_d),  64'd0);

      // mode off: no arming, and off inside a window skips the check
      do_reset(2'b00);
      put(ret_e, 1'b1, 1'b1);
      tick();
      chk("off_noarm", 64'(busy_a), 64'd0);
      mode = 2'b11;
      put(ret_e, 1'b1, 1'b1);
      tick();
      chk("enf11_arm", 64'(busy_a), 64'd1);
      mode = 2'b00;
      put(bad_e, 1'b1, 1'b1);
      chk("off_exv", 64'(eo_a.ex.valid), 64'd0);
      tick();
      chk("off_busy", 64'(busy_a), 64'd0);
      chk("off_cnt",  64'(cnt_a),  64'd0);

      // pre-existing exception in the window passes untouched
      do_reset(2'b10);
      put(ret_e, 1'b1, 1'b1);
      tick();
      put(exc_e, 1'b1, 1'b1);
      chk("exc_cause", eo_a.ex.cause, 64'd5);
      tick();
      chk("exc_viol", 64'(viol_a), 64'd0);
      chk("exc_busy", 64'(busy_a), 64'd0);

      // RET inside the window is a mismatch and does not re-arm
      do_reset(2'b10);
      put(ret_e, 1'b1, 1'b1);
      tick();
      put(ret_e, 1'b1, 1'b1);
      chk("reret_exv", 64'(eo_a.ex.valid), 64'd1);
      tick();
      chk("reret_busy", 64'(busy_a), 64'd0);
      chk("reret_viol", 64'(viol_a), 64'd1);
      chk("reret_cnt",  64'(cnt_a),  64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
